// File: rtl/rgb_fade_sequencer.sv
// Three-channel colour-wheel fader: one channel ramps per segment, then holds.
// Produces PWM duty values for R/G/B with pause, restart and a segment-done strobe.
module rgb_fade_sequencer #(
  parameter int PWM_MAX_VALUE = 1200,
  parameter int TICK_DIVIDER  = 5000,
  parameter int RAMP_STEPS    = 400,
  parameter int HOLD_TICKS    = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        restart,
  output logic [10:0] red_duty,
  output logic [10:0] green_duty,
  output logic [10:0] blue_duty,
  output logic [2:0]  segment,
  output logic        seg_done,
  output logic        busy
);

  localparam int STEP   = PWM_MAX_VALUE / RAMP_STEPS;
  localparam int PRE_W  = (TICK_DIVIDER > 1) ? $clog2(TICK_DIVIDER) : 1;
  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [10:0]       MAX_DUTY  = 11'(PWM_MAX_VALUE);
  localparam logic [10:0]       STEP_DUTY = 11'(STEP);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIVIDER - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  // Packed as {blue, green, red}: index 0 = R, 1 = G, 2 = B.
  localparam logic [2:0][10:0]  RESET_DUTY = {11'd0, 11'd0, MAX_DUTY};

  generate
    if (STEP < 1) begin : g_step_check
      $error("rgb_fade_sequencer: RAMP_STEPS must not exceed PWM_MAX_VALUE");
    end
    if (PWM_MAX_VALUE > 2047) begin : g_max_check
      $error("rgb_fade_sequencer: PWM_MAX_VALUE must fit the 11-bit duty ports");
    end
    if (TICK_DIVIDER < 1) begin : g_div_check
      $error("rgb_fade_sequencer: TICK_DIVIDER must be at least 1");
    end
    if (HOLD_TICKS < 1) begin : g_hold_check
      $error("rgb_fade_sequencer: HOLD_TICKS must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [2:0]        seg_q, seg_d;
  logic [2:0][10:0]  duty_q, duty_d;

  logic        tick;
  logic        hold_end;
  logic        ramp_up;
  logic        at_end;
  logic [1:0]  ch;
  logic [10:0] cur;
  logic [10:0] next_val;
  logic [11:0] up_sum;

  // Moving channel and its next value for the current segment; endpoints are clamped.
  always_comb begin
    tick     = enable && (state_q != IDLE) && (pre_q == PRE_LAST);
    hold_end = tick && !restart && (state_q == HOLD) && (hold_q == HOLD_LAST);
    ramp_up  = ~seg_q[0];
    case (seg_q)
      3'd0, 3'd3: ch = 2'd1;
      3'd1, 3'd4: ch = 2'd0;
      default:    ch = 2'd2;
    endcase
    cur    = duty_q[ch];
    up_sum = {1'b0, cur} + {1'b0, STEP_DUTY};
    if (ramp_up) begin
      at_end   = (up_sum >= {1'b0, MAX_DUTY});
      next_val = at_end ? MAX_DUTY : up_sum[10:0];
    end else begin
      at_end   = (cur <= STEP_DUTY);
      next_val = at_end ? 11'd0 : (cur - STEP_DUTY);
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    hold_d  = hold_q;
    seg_d   = seg_q;
    duty_d  = duty_q;
    if (restart) begin
      state_d = IDLE;
      pre_d   = '0;
      hold_d  = '0;
      seg_d   = 3'd0;
      duty_d  = RESET_DUTY;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_d = RAMP;
            pre_d   = '0;
          end
        end
        RAMP: begin
          if (enable) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
          end
          if (tick) begin
            duty_d[ch] = next_val;
            if (at_end) begin
              state_d = HOLD;
              hold_d  = '0;
            end
          end
        end
        HOLD: begin
          if (enable) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
          end
          if (tick) begin
            if (hold_q == HOLD_LAST) begin
              hold_d  = '0;
              seg_d   = (seg_q == 3'd5) ? 3'd0 : seg_q + 3'd1;
              state_d = RAMP;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      hold_q  <= '0;
      seg_q   <= 3'd0;
      duty_q  <= RESET_DUTY;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      hold_q  <= hold_d;
      seg_q   <= seg_d;
      duty_q  <= duty_d;
    end
  end

  assign red_duty   = duty_q[0];
  assign green_duty = duty_q[1];
  assign blue_duty  = duty_q[2];
  assign segment    = seg_q;
  assign seg_done   = hold_end;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer: a segment-level reference model feeds a scoreboard queue,
// plus anchored timeline checks and a second instance with a non-divisible step.
module tb_rgb_fade_sequencer;

  localparam int M  = 12;
  localparam int S  = 3;
  localparam int TD = 4;
  localparam int HT = 2;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        restart;
  logic [10:0] red_duty, green_duty, blue_duty;
  logic [2:0]  segment;
  logic        seg_done, busy;

  logic        enable2, restart2;
  logic [10:0] red2, green2, blue2;
  logic [2:0]  segment2;
  logic        seg_done2, busy2;

  rgb_fade_sequencer #(
    .PWM_MAX_VALUE(M), .TICK_DIVIDER(TD), .RAMP_STEPS(4), .HOLD_TICKS(HT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .restart(restart),
    .red_duty(red_duty), .green_duty(green_duty), .blue_duty(blue_duty),
    .segment(segment), .seg_done(seg_done), .busy(busy)
  );

  rgb_fade_sequencer #(
    .PWM_MAX_VALUE(10), .TICK_DIVIDER(4), .RAMP_STEPS(4), .HOLD_TICKS(2)
  ) dut2 (
    .clk(clk), .rst(rst), .enable(enable2), .restart(restart2),
    .red_duty(red2), .green_duty(green2), .blue_duty(blue2),
    .segment(segment2), .seg_done(seg_done2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_RAMP, M_HOLD} mstate_t;
  typedef struct {
    int r; int g; int b; int seg; int done; int busy;
  } exp_t;

  exp_t    sb_q[$];
  int      q2[$];
  mstate_t m_state;
  int      m_seg, m_k, m_hold, m_pres;
  int      total, bad;
  int      done_seen, blue_peak;

  task automatic checkOutput(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Segment order: 0 G up, 1 R down, 2 B up, 3 G down, 4 R up, 5 B down.
  function automatic int move_ch(input int seg);
    case (seg % 3)
      0:       return 1;
      1:       return 0;
      default: return 2;
    endcase
  endfunction

  function automatic int move_val(input int seg, input int k);
    if (seg % 2 == 0) return (k * S >= M) ? M : k * S;
    return (M - k * S <= 0) ? 0 : M - k * S;
  endfunction

  // Colour at the start of each segment, as {B,G,R} full-scale flags.
  function automatic int base_val(input int seg, input int ch);
    logic [2:0] pat;
    case (seg)
      0:       pat = 3'b001;
      1:       pat = 3'b011;
      2:       pat = 3'b010;
      3:       pat = 3'b110;
      4:       pat = 3'b100;
      default: pat = 3'b101;
    endcase
    return pat[ch] ? M : 0;
  endfunction

  function automatic int exp_duty(input int ch);
    if (ch == move_ch(m_seg)) return move_val(m_seg, m_k);
    return base_val(m_seg, ch);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_seg   = 0;
    m_k     = 0;
    m_hold  = 0;
    m_pres  = 0;
  endtask

  task automatic model_expect(input logic en, input logic rs, output exp_t e);
    e.r    = exp_duty(0);
    e.g    = exp_duty(1);
    e.b    = exp_duty(2);
    e.seg  = m_seg;
    e.busy = (m_state != M_IDLE) ? 1 : 0;
    e.done = (en && !rs && m_state == M_HOLD && m_hold == HT - 1 && m_pres == TD - 1) ? 1 : 0;
  endtask

  task automatic model_step(input logic en, input logic rs, output exp_t e);
    logic tk;
    if (rs) begin
      model_reset();
    end else if (m_state == M_IDLE) begin
      if (en) begin
        m_state = M_RAMP;
        m_pres  = 0;
      end
    end else if (en) begin
      tk     = (m_pres == TD - 1);
      m_pres = tk ? 0 : m_pres + 1;
      if (tk && m_state == M_RAMP) begin
        m_k++;
        if (move_val(m_seg, m_k) == ((m_seg % 2 == 0) ? M : 0)) begin
          m_state = M_HOLD;
          m_hold  = 0;
        end
      end else if (tk) begin
        if (m_hold == HT - 1) begin
          m_hold  = 0;
          m_seg   = (m_seg + 1) % 6;
          m_k     = 0;
          m_state = M_RAMP;
        end else begin
          m_hold++;
        end
      end
    end
    model_expect(en, rs, e);
  endtask

  task automatic compare_entry(input string tag);
    exp_t e;
    e = sb_q.pop_front();
    checkOutput({tag, "_r"}, red_duty, e.r);
    checkOutput({tag, "_g"}, green_duty, e.g);
    checkOutput({tag, "_b"}, blue_duty, e.b);
    checkOutput({tag, "_seg"}, segment, e.seg);
    checkOutput({tag, "_done"}, seg_done, e.done);
    checkOutput({tag, "_busy"}, busy, e.busy);
  endtask

  // Drive one cycle per iteration; outputs are compared on the following falling edge.
  task automatic applyStimulus(input logic en, input logic rs, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      enable  = en;
      restart = rs;
      model_step(en, rs, e);
      sb_q.push_back(e);
      @(negedge clk);
      compare_entry("sb");
      if (seg_done) done_seen++;
      if (int'(blue_duty) > blue_peak) blue_peak = int'(blue_duty);
    end
  endtask

  initial begin
    exp_t e;
    total = 0; bad = 0; done_seen = 0; blue_peak = 0;
    rst = 1'b1; enable = 1'b0; restart = 1'b0;
    enable2 = 1'b0; restart2 = 1'b0;
    model_reset();

    @(negedge clk);
    model_expect(1'b0, 1'b0, e);
    sb_q.push_back(e);
    compare_entry("rst");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 5);
    checkOutput("idle_r", red_duty, 12);
    checkOutput("idle_busy", busy, 0);

    applyStimulus(1'b1, 1'b0, 5);
    checkOutput("tick1_g", green_duty, 3);
    checkOutput("tick1_busy", busy, 1);
    applyStimulus(1'b1, 1'b0, 4);
    checkOutput("tick2_g", green_duty, 6);
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("pause_g", green_duty, 6);
    applyStimulus(1'b1, 1'b0, 2);
    checkOutput("resume_early_g", green_duty, 6);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("resume_tick_g", green_duty, 9);

    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("pre_restart_g", green_duty, 9);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("restart_g", green_duty, 0);
    checkOutput("restart_r", red_duty, 12);
    checkOutput("restart_busy", busy, 0);

    applyStimulus(1'b0, 1'b0, 2);
    done_seen = 0;
    blue_peak = 0;
    applyStimulus(1'b1, 1'b0, 145);
    checkOutput("wheel_done_count", done_seen, 6);
    checkOutput("wheel_blue_peak", blue_peak, 12);
    checkOutput("wheel_seg", segment, 0);
    checkOutput("wheel_r", red_duty, 12);
    checkOutput("wheel_b", blue_duty, 0);

    applyStimulus(1'b1, 1'b0, 18);
    checkOutput("hold_g", green_duty, 12);
    checkOutput("hold_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    model_expect(enable, 1'b0, e);
    sb_q.push_back(e);
    compare_entry("arst");
    checkOutput("arst_g", green_duty, 0);
    checkOutput("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 80) == 0, 1);
    end
    applyStimulus(1'b0, 1'b0, 1);

    // Second instance: max 10, step 2, so the fifth tick lands exactly on full scale.
    for (int v = 2; v <= 10; v += 2) q2.push_back(v);
    q2.push_back(10);
    enable2 = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= 6; t++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("dut2_g", green2, q2.pop_front());
    end
    checkOutput("dut2_hold_r", red2, 10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("dut2_done", seg_done2, 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("dut2_seg", segment2, 1);
    checkOutput("dut2_done_low", seg_done2, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("dut2_r_down", red2, 8);
    enable2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
